coherence_ctrl: RTL and testbench
=================================

COHERENCE_CTRL -- requirements
Module: coherence_ctrl

Interface
REQ-001 CLK  in  1  system clock; all state updates on rising edge.
REQ-002 nRST  in  1  asynchronous, active-low reset.
REQ-003 iREN[1:0], iaddr[2]  in  1/32 each  per-core icache read request and word address.
REQ-004 iload[2], iwait[1:0]  out  32/1  icache read data; iwait low for exactly one cycle when the word completes.
REQ-005 dREN[1:0], dWEN[1:0], daddr[2], dstore[2]  in  1/1/32/32  per-core dcache word request, address and write data.
REQ-006 dload[2], dwait[1:0]  out  32/1  dcache read data; dwait low for exactly one cycle per completed word.
REQ-007 cctrans[1:0], ccwrite[1:0]  in  1 each  cctrans: request needs exclusivity; ccwrite: snooped cache holds the line dirty.
REQ-008 ccwait[1:0], ccinv[1:0], ccsnoopaddr[2]  out  1/1/32  snoop strobe, invalidate and snoop address to each dcache.
REQ-009 ramREN, ramWEN, ramaddr, ramstore  out  1/1/32/32  single RAM port.
REQ-010 ramload, ramstate  in  32/ramstate_t  RAM data and status (FREE, BUSY, ACCESS, ERROR).

Function
REQ-011 FSM states: IDLE, ARB, SNOOP, C2C, RAMRD, RAMWR, UPGRADE, IFETCH.
REQ-012 IDLE -> ARB when any request pending; otherwise stay, all RAM/cc outputs low.
REQ-013 ARB priority: dcache (dREN|dWEN|cctrans) over icache; between cores round-robin on a 1-bit last-grant register, toggled on each dcache/icache grant completion.
REQ-014 ARB -> RAMWR if winner has dWEN (writeback/flush): ramWEN=1, ramaddr=daddr, ramstore=dstore; no snoop.
REQ-015 ARB -> SNOOP if winner has dREN; ARB -> UPGRADE if winner has cctrans without dREN/dWEN.
REQ-016 SNOOP: one cycle; ccwait[other]=1, ccsnoopaddr[other]=daddr[winner], ccinv[other]=cctrans[winner]; next C2C if ccwrite[other] else RAMRD.
REQ-017 C2C: ccwait[other] held; dload[winner]=dstore[other]; ramWEN=1 with same data/address (write-back of dirty word); on ramstate==ACCESS dwait[winner] low one cycle, -> IDLE.
REQ-018 RAMRD: ramREN=1, ramaddr=daddr[winner]; on ACCESS dload[winner]=ramload, dwait[winner] low one cycle, -> IDLE.
REQ-019 UPGRADE: one cycle, ccwait[other]=ccinv[other]=1, ccsnoopaddr[other]=daddr[winner]; dwait[winner] low that cycle; -> IDLE.
REQ-020 IFETCH: ramREN=1, ramaddr=iaddr[winner]; on ACCESS iload=ramload, iwait low one cycle, -> IDLE.
REQ-021 ramstate ERROR treated as BUSY (retry); FREE/BUSY hold current state.
REQ-022 ramREN and ramWEN never asserted together; ccwait never asserted to the winner.
REQ-023 Request withdrawn mid-transaction: abort to IDLE next cycle, no dwait/iwait pulse.
REQ-024 Simultaneous same-core icache and dcache requests: dcache served first; icache waits.
REQ-025 Both cores snooping the same line: serialized by arbitration; second sees post-invalidate state.
REQ-026 Worst-case RAM latency unbounded; no timeout.

Reset
REQ-027 nRST low: state=IDLE, last-grant=0, winner=0 immediately.
REQ-028 During reset: iwait=dwait=2'b11, ccwait=ccinv=0, ramREN=ramWEN=0, ramaddr/ramstore=0.
REQ-029 Reset mid-transaction drops the transaction; no partial completion signalled.

Structure
REQ-030 ccstate_t enum and CPUS=2 constant in cpu_types_pkg; ramstate_t reused from it.
REQ-031 Round-robin arbiter as sub-module rr_arbiter (2 requesters, grant + last-grant register).
REQ-032 Datapath outputs combinational from state/winner; only state, winner, last-grant are registered.

Verification
REQ-033 Core0 dREN 0x100, core1 clean, RAM ACCESS after 2 cycles -> SNOOP then RAMRD, dload[0]=ramload, dwait[0] low once.
REQ-034 Core1 dREN+cctrans 0x200, core0 ccwrite=1, dstore[0]=0xDEADBEEF -> ccinv[0]=1, ramWEN to 0x200, dload[1]=0xDEADBEEF.
REQ-035 Both cores dREN same cycle, last-grant=0 -> core1 served first, then core0.
REQ-036 Core0 cctrans only on 0x300 -> single-cycle ccinv[1], ccsnoopaddr[1]=0x300, dwait[0] low same cycle.
REQ-037 Core0 iREN and dWEN together -> RAMWR completes before IFETCH; iload correct.
REQ-038 nRST low during C2C -> outputs at reset values, next request processed normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared types for the two-core coherence controller: core count, word
// type, RAM port status encoding and the controller state encoding.
package cpu_types_pkg;

  localparam int CPUS = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    SNOOP   = 3'd2,
    C2C     = 3'd3,
    RAMRD   = 3'd4,
    RAMWR   = 3'd5,
    UPGRADE = 3'd6,
    IFETCH  = 3'd7
  } ccstate_t;

endpackage

// File: rtl/coherence_ctrl_if.sv
// coherence_ctrl_if
// Bundle between the two cores' caches, the single RAM port and the
// coherence controller.
//   master : cache/RAM side (drives requests, snoop replies, RAM status/data)
//   slave  : controller side (drives waits, load data, snoops, RAM commands)
interface coherence_ctrl_if;
  import cpu_types_pkg::*;

  // icache
  logic [CPUS-1:0]       iREN;
  logic [CPUS-1:0][31:0] iaddr;
  logic [CPUS-1:0][31:0] iload;
  logic [CPUS-1:0]       iwait;
  // dcache
  logic [CPUS-1:0]       dREN;
  logic [CPUS-1:0]       dWEN;
  logic [CPUS-1:0][31:0] daddr;
  logic [CPUS-1:0][31:0] dstore;
  logic [CPUS-1:0][31:0] dload;
  logic [CPUS-1:0]       dwait;
  // coherence
  logic [CPUS-1:0]       cctrans;
  logic [CPUS-1:0]       ccwrite;
  logic [CPUS-1:0]       ccwait;
  logic [CPUS-1:0]       ccinv;
  logic [CPUS-1:0][31:0] ccsnoopaddr;
  // RAM
  logic                  ramREN;
  logic                  ramWEN;
  word_t                 ramaddr;
  word_t                 ramstore;
  word_t                 ramload;
  ramstate_t             ramstate;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite,
           ramload, ramstate,
    input  iload, iwait, dload, dwait, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite,
           ramload, ramstate,
    output iload, iwait, dload, dwait, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Two-requester round-robin arbiter. grant is combinational; the only state
// is the last-grant bit, which flips each time a granted transaction
// completes.
//   CLK, nRST : clock, async active-low reset
//   req       : request vector (one bit per requester)
//   done      : a granted transaction completed this cycle
//   grant     : index of the selected requester
module rr_arbiter (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [1:0] req,
  input  logic       done,
  output logic       grant
);

  logic last;

  // On contention the requester that did not go last wins; a lone requester
  // always wins.
  always_comb begin
    if (req[0] && req[1]) grant = ~last;
    else                  grant = req[1];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     last <= 1'b0;
    else if (done) last <= ~last;
  end

endmodule

// File: rtl/coherence_ctrl.sv
// coherence_ctrl
// Snooping coherence controller for two cores sharing one RAM port.
// Dcache traffic beats icache traffic; cores alternate on contention.
//   CLK, nRST : clock, async active-low reset
//   bus       : cache/RAM bundle (slave side)
//
// state   | meaning
// IDLE    | no transaction; waits for any request
// ARB     | pick winner and transaction type
// SNOOP   | one cycle snoop of the other core for a dcache read
// C2C     | other core supplies dirty word; same word written back to RAM
// RAMRD   | dcache word read from RAM
// RAMWR   | dcache writeback/flush to RAM
// UPGRADE | one cycle invalidate of the other core, no data moved
// IFETCH  | icache word read from RAM
module coherence_ctrl
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  coherence_ctrl_if.slave  bus
);

  ccstate_t        state;
  logic            winner;
  logic            other;
  logic [CPUS-1:0] dreq;
  logic [CPUS-1:0] arb_req;
  logic            grant;
  logic            cpl;
  logic            ram_ok;
  logic            d_rd, d_wr, d_tr, i_rd;

  assign other   = ~winner;
  assign dreq    = bus.dREN | bus.dWEN | bus.cctrans;
  assign arb_req = (|dreq) ? dreq : bus.iREN;
  // ERROR is deliberately not ACCESS: the transaction simply retries.
  assign ram_ok  = (bus.ramstate == ACCESS);

  // Winner still holding its request; a drop aborts without completion.
  assign d_rd = bus.dREN[winner];
  assign d_wr = bus.dWEN[winner];
  assign d_tr = bus.cctrans[winner];
  assign i_rd = bus.iREN[winner];

  rr_arbiter u_arb (
    .CLK   (CLK),
    .nRST  (nRST),
    .req   (arb_req),
    .done  (cpl),
    .grant (grant)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      winner <= 1'b0;
    end else begin
      unique case (state)
        IDLE:    if ((|dreq) || (|bus.iREN)) state <= ARB;
        ARB: begin
          winner <= grant;
          if (|dreq) begin
            if (bus.dWEN[grant])      state <= RAMWR;
            else if (bus.dREN[grant]) state <= SNOOP;
            else                      state <= UPGRADE;
          end else if (|bus.iREN) begin
            state <= IFETCH;
          end else begin
            state <= IDLE;
          end
        end
        SNOOP: begin
          if (!d_rd)                     state <= IDLE;
          else if (bus.ccwrite[other])   state <= C2C;
          else                           state <= RAMRD;
        end
        C2C, RAMRD: if (!d_rd || ram_ok) state <= IDLE;
        RAMWR:      if (!d_wr || ram_ok) state <= IDLE;
        UPGRADE:                         state <= IDLE;
        IFETCH:     if (!i_rd || ram_ok) state <= IDLE;
        default:                         state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.iwait       = '1;
    bus.dwait       = '1;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.ccwait      = '0;
    bus.ccinv       = '0;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;
    cpl             = 1'b0;
    unique case (state)
      SNOOP: begin
        bus.ccwait[other]      = 1'b1;
        bus.ccinv[other]       = bus.cctrans[winner];
        bus.ccsnoopaddr[other] = bus.daddr[winner];
      end
      C2C: begin
        bus.ccwait[other]      = 1'b1;
        bus.ccinv[other]       = bus.cctrans[winner];
        bus.ccsnoopaddr[other] = bus.daddr[winner];
        bus.dload[winner]      = bus.dstore[other];
        bus.ramWEN             = 1'b1;
        bus.ramaddr            = bus.daddr[winner];
        bus.ramstore           = bus.dstore[other];
        cpl                    = ram_ok && d_rd;
        if (cpl) bus.dwait[winner] = 1'b0;
      end
      RAMRD: begin
        bus.ramREN        = 1'b1;
        bus.ramaddr       = bus.daddr[winner];
        bus.dload[winner] = bus.ramload;
        cpl               = ram_ok && d_rd;
        if (cpl) bus.dwait[winner] = 1'b0;
      end
      RAMWR: begin
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = bus.daddr[winner];
        bus.ramstore = bus.dstore[winner];
        cpl          = ram_ok && d_wr;
        if (cpl) bus.dwait[winner] = 1'b0;
      end
      UPGRADE: begin
        bus.ccwait[other]      = 1'b1;
        bus.ccinv[other]       = 1'b1;
        bus.ccsnoopaddr[other] = bus.daddr[winner];
        cpl                    = d_tr;
        if (cpl) bus.dwait[winner] = 1'b0;
      end
      IFETCH: begin
        bus.ramREN        = 1'b1;
        bus.ramaddr       = bus.iaddr[winner];
        bus.iload[winner] = bus.ramload;
        cpl               = ram_ok && i_rd;
        if (cpl) bus.iwait[winner] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
// tb_coherence_ctrl
// Directed bench for coherence_ctrl: RAM model with fixed latency and a
// per-address default pattern, caches that drop a request on its wait pulse.
module tb_coherence_ctrl;
  import cpu_types_pkg::*;

  localparam int RAM_LAT = 2;

  logic CLK;
  logic nRST;

  coherence_ctrl_if bus ();

  coherence_ctrl dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // RAM model
  logic [31:0] mem [256];
  bit [255:0]  mem_wr;
  int          ram_cnt;
  logic        ram_force_en;
  ramstate_t   ram_force;

  always @(posedge CLK) begin
    if (bus.ramREN || bus.ramWEN) ram_cnt <= ram_cnt + 1;
    else                          ram_cnt <= 0;
    if (bus.ramWEN && bus.ramstate == ACCESS) begin
      mem[bus.ramaddr[9:2]]    <= bus.ramstore;
      mem_wr[bus.ramaddr[9:2]] <= 1'b1;
    end
  end

  always_comb begin
    if (ram_force_en)                                         bus.ramstate = ram_force;
    else if ((bus.ramREN || bus.ramWEN) && ram_cnt >= RAM_LAT) bus.ramstate = ACCESS;
    else if (bus.ramREN || bus.ramWEN)                         bus.ramstate = BUSY;
    else                                                       bus.ramstate = FREE;
    bus.ramload = mem_wr[bus.ramaddr[9:2]] ? mem[bus.ramaddr[9:2]]
                                           : (32'hC0DE_0000 | bus.ramaddr);
  end

  // checking
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // per-scenario observations
  int          dpulse [CPUS];
  int          ipulse [CPUS];
  int          ccw_cnt [CPUS];
  int          inv_cnt [CPUS];
  logic [31:0] dload_cap [CPUS];
  logic [31:0] iload_cap [CPUS];
  logic [31:0] snoop_addr [CPUS];
  logic [1:0]  inv_at_pulse;
  int          rd_cyc, wr_cyc, both_cnt;
  logic [31:0] waddr, wdata;
  int          order [$];

  task automatic clear_obs();
    for (int c = 0; c < CPUS; c++) begin
      dpulse[c] = 0; ipulse[c] = 0; ccw_cnt[c] = 0; inv_cnt[c] = 0;
      dload_cap[c] = '0; iload_cap[c] = '0; snoop_addr[c] = '0;
    end
    inv_at_pulse = '0;
    rd_cyc = 0; wr_cyc = 0;
    waddr = '0; wdata = '0;
    order.delete();
  endtask

  task automatic sample();
    for (int c = 0; c < CPUS; c++) begin
      if (!bus.dwait[c]) begin
        dpulse[c]++;
        dload_cap[c] = bus.dload[c];
        inv_at_pulse = bus.ccinv;
        order.push_back(c);
      end
      if (!bus.iwait[c]) begin
        ipulse[c]++;
        iload_cap[c] = bus.iload[c];
        order.push_back(2 + c);
      end
      if (bus.ccwait[c]) begin
        ccw_cnt[c]++;
        snoop_addr[c] = bus.ccsnoopaddr[c];
        if (bus.ccinv[c]) inv_cnt[c]++;
      end
    end
    if (bus.ramREN) rd_cyc++;
    if (bus.ramWEN) begin
      wr_cyc++;
      waddr = bus.ramaddr;
      wdata = bus.ramstore;
    end
    if (bus.ramREN && bus.ramWEN) both_cnt++;
  endtask

  // Runs a fixed number of cycles; a cache drops its request right after
  // the edge on which its wait pulse was seen.
  task automatic run(input int cycles);
    logic [1:0] dd, di;
    for (int n = 0; n < cycles; n++) begin
      @(negedge CLK);
      sample();
      dd = ~bus.dwait;
      di = ~bus.iwait;
      @(posedge CLK);
      #1;
      for (int c = 0; c < CPUS; c++) begin
        if (dd[c]) begin
          bus.dREN[c] = 1'b0; bus.dWEN[c] = 1'b0; bus.cctrans[c] = 1'b0;
        end
        if (di[c]) bus.iREN[c] = 1'b0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_dwait"},  {30'd0, bus.dwait}, 32'd3);
    check_eq({tag, "_iwait"},  {30'd0, bus.iwait}, 32'd3);
    check_eq({tag, "_cc"},     {28'd0, bus.ccwait, bus.ccinv}, 32'd0);
    check_eq({tag, "_ramen"},  {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    check_eq({tag, "_ramaddr"}, bus.ramaddr, 32'd0);
    check_eq({tag, "_ramstore"}, bus.ramstore, 32'd0);
  endtask

  initial begin
    nRST = 1'b0;
    ram_force_en = 1'b0;
    ram_force    = BUSY;
    both_cnt     = 0;
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0; bus.cctrans = '0; bus.ccwrite = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    clear_obs();

    // reset values
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    nRST = 1'b1;
    @(posedge CLK); #1;

    // core0 read, core1 clean: SNOOP then RAMRD (RAM ACCESS on 3rd cycle)
    clear_obs();
    bus.daddr[0] = 32'h100;
    bus.dREN[0]  = 1'b1;
    run(15);
    check_eq("rd_dpulse0",   dpulse[0], 1);
    check_eq("rd_dload0",    dload_cap[0], 32'hC0DE_0100);
    check_eq("rd_snoopaddr1", snoop_addr[1], 32'h100);
    check_eq("rd_ccw1",      ccw_cnt[1], 1);
    check_eq("rd_inv1",      inv_cnt[1], 0);
    check_eq("rd_ccw_winner", ccw_cnt[0], 0);
    check_eq("rd_ramcyc",    rd_cyc, 3);
    check_eq("rd_nowrite",   wr_cyc, 0);

    // core1 read-exclusive, core0 dirty: cache-to-cache with writeback
    clear_obs();
    bus.ccwrite[0] = 1'b1;
    bus.dstore[0]  = 32'hDEAD_BEEF;
    bus.daddr[1]   = 32'h200;
    bus.dREN[1]    = 1'b1;
    bus.cctrans[1] = 1'b1;
    run(15);
    bus.ccwrite[0] = 1'b0;
    check_eq("c2c_inv0",      inv_cnt[0] > 0, 1);
    check_eq("c2c_snoopaddr0", snoop_addr[0], 32'h200);
    check_eq("c2c_waddr",     waddr, 32'h200);
    check_eq("c2c_wdata",     wdata, 32'hDEAD_BEEF);
    check_eq("c2c_dload1",    dload_cap[1], 32'hDEAD_BEEF);
    check_eq("c2c_dpulse1",   dpulse[1], 1);
    check_eq("c2c_ccw_winner", ccw_cnt[1], 0);

    // both cores read together with last-grant back at 0: core1 first
    clear_obs();
    bus.daddr[0] = 32'h104;
    bus.daddr[1] = 32'h108;
    bus.dREN     = 2'b11;
    run(25);
    check_eq("rr_count",  order.size(), 2);
    if (order.size() == 2) begin
      check_eq("rr_first",  order[0], 1);
      check_eq("rr_second", order[1], 0);
    end
    check_eq("rr_dload0", dload_cap[0], 32'hC0DE_0104);
    check_eq("rr_dload1", dload_cap[1], 32'hC0DE_0108);

    // core0 upgrade: single-cycle invalidate of core1
    clear_obs();
    bus.daddr[0]   = 32'h300;
    bus.cctrans[0] = 1'b1;
    run(8);
    check_eq("upg_dpulse0",    dpulse[0], 1);
    check_eq("upg_ccw1",       ccw_cnt[1], 1);
    check_eq("upg_inv1",       inv_cnt[1], 1);
    check_eq("upg_snoopaddr1", snoop_addr[1], 32'h300);
    check_eq("upg_inv_at_pulse", {30'd0, inv_at_pulse}, 32'd2);
    check_eq("upg_noram",      rd_cyc + wr_cyc, 0);

    // core0 writeback and ifetch together: writeback first
    clear_obs();
    bus.daddr[0]  = 32'h10C;
    bus.dstore[0] = 32'h1234_5678;
    bus.dWEN[0]   = 1'b1;
    bus.iaddr[0]  = 32'h200;
    bus.iREN[0]   = 1'b1;
    run(20);
    check_eq("wbi_count", order.size(), 2);
    if (order.size() == 2) begin
      check_eq("wbi_first",  order[0], 0);
      check_eq("wbi_second", order[1], 2);
    end
    check_eq("wbi_waddr", waddr, 32'h10C);
    check_eq("wbi_wdata", wdata, 32'h1234_5678);
    check_eq("wbi_iload0", iload_cap[0], 32'hDEAD_BEEF);

    // RAM ERROR is retried until ACCESS
    clear_obs();
    bus.iaddr[1] = 32'h104;
    bus.iREN[1]  = 1'b1;
    ram_force_en = 1'b1;
    ram_force    = ERROR;
    run(8);
    check_eq("err_no_pulse", ipulse[1], 0);
    ram_force_en = 1'b0;
    run(8);
    check_eq("err_ipulse1", ipulse[1], 1);
    check_eq("err_iload1",  iload_cap[1], 32'hC0DE_0104);

    // request withdrawn mid-read: back to idle, no pulse
    clear_obs();
    ram_force_en = 1'b1;
    ram_force    = BUSY;
    bus.daddr[0] = 32'h100;
    bus.dREN[0]  = 1'b1;
    run(6);
    bus.dREN[0]  = 1'b0;
    run(4);
    check_eq("wd_no_pulse", dpulse[0], 0);
    @(negedge CLK);
    check_eq("wd_idle", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    @(posedge CLK); #1;

    // reset while in C2C, then a normal request
    clear_obs();
    bus.ccwrite[1] = 1'b1;
    bus.dstore[1]  = 32'h0BAD_F00D;
    bus.daddr[0]   = 32'h100;
    bus.dREN[0]    = 1'b1;
    run(6);
    @(negedge CLK);
    check_eq("c2crst_in_c2c", {31'd0, bus.ramWEN}, 32'd1);
    check_eq("c2crst_store",  bus.ramstore, 32'h0BAD_F00D);
    nRST = 1'b0;
    #2;
    check_reset_outputs("c2crst");
    bus.dREN       = '0;
    bus.ccwrite    = '0;
    ram_force_en   = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    check_eq("c2crst_aborted", dpulse[0], 0);
    bus.daddr[1] = 32'h108;
    bus.dREN[1]  = 1'b1;
    run(15);
    check_eq("c2crst_dpulse1", dpulse[1], 1);
    check_eq("c2crst_dload1",  dload_cap[1], 32'hC0DE_0108);

    check_eq("ram_rd_wr_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
